reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_if.sv | 47 ++++
 rtl/reorder_buffer.sv | 98 +++++++++
 tb/tb_reorder_buffer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if
//   Groups the reorder buffer's functional-unit result bus and its three
//   commit channels (register writeback, branch resolution, free-list retire).
//   master : functional-unit / pipeline side (drives results, observes commits)
//   slave  : reorder buffer side
//   Signals:
//     rob_transmit, robid[3:0], flags[7:0], wbs[7:0], value[7:0]  (result in)
//     prf_transmit, prf_id[3:0], prf_value[7:0]                   (writeback)
//     branch_transmit, new_pc[7:0], branch_not_taken              (branch)
//     retire_transmit, retire_id[3:0]                             (free list)
//     dup_err                                                     (sticky error)
interface reorder_buffer_if;
  logic       rob_transmit;
  logic [3:0] robid;
  logic [7:0] flags;
  logic [7:0] wbs;
  logic [7:0] value;

  logic       prf_transmit;
  logic [3:0] prf_id;
  logic [7:0] prf_value;

  logic       branch_transmit;
  logic [7:0] new_pc;
  logic       branch_not_taken;

  logic       retire_transmit;
  logic [3:0] retire_id;

  logic       dup_err;

  modport master (
    output rob_transmit, robid, flags, wbs, value,
    input  prf_transmit, prf_id, prf_value,
    input  branch_transmit, new_pc, branch_not_taken,
    input  retire_transmit, retire_id,
    input  dup_err
  );

  modport slave (
    input  rob_transmit, robid, flags, wbs, value,
    output prf_transmit, prf_id, prf_value,
    output branch_transmit, new_pc, branch_not_taken,
    output retire_transmit, retire_id,
    output dup_err
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   16-entry reorder buffer. Functional units deliver results out of order,
//   tagged with their fetch-order index (robid). Entries commit strictly in
//   fetch order, one per cycle, from the head pointer. Each commit drives
//   registered, single-cycle pulses on the writeback, branch and retire
//   channels according to the entry's flags.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-low reset
//     bus  : reorder_buffer_if.slave (result input, commit outputs, dup_err)
//   Flags: bit0 branch, bit1 register write, bit2 branch taken.
module reorder_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  reorder_buffer_if.slave   bus
);

  localparam int unsigned IDW = $clog2(DEPTH);

  logic [DEPTH-1:0] done;
  logic [2:0]       ent_flags [DEPTH];
  logic [7:0]       ent_wbs   [DEPTH];
  logic [7:0]       ent_value [DEPTH];
  logic [IDW-1:0]   head;

  logic           commit;
  logic           wr_ok;
  logic           dup;
  logic [2:0]     h_flags;
  logic [7:0]     h_wbs;
  logic [7:0]     h_value;
  logic           do_prf;
  logic           do_br;

  // A write to a done entry is always dropped. When that entry is also the
  // one committing this cycle, the commit consumes the old contents and the
  // entry ends not-done, so both duplicate cases share one rule.
  always_comb begin
    commit  = done[head];
    wr_ok   = bus.rob_transmit && !done[bus.robid];
    dup     = bus.rob_transmit &&  done[bus.robid];
    h_flags = ent_flags[head];
    h_wbs   = ent_wbs[head];
    h_value = ent_value[head];
    do_prf  = commit && h_flags[1];
    do_br   = commit && h_flags[0];
  end

  // Entry payload needs no reset: it is only observed through a done bit.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ent_flags[bus.robid] <= bus.flags[2:0];
      ent_wbs[bus.robid]   <= bus.wbs;
      ent_value[bus.robid] <= bus.value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done                 <= '0;
      head                 <= '0;
      bus.dup_err          <= 1'b0;
      bus.prf_transmit     <= 1'b0;
      bus.prf_id           <= '0;
      bus.prf_value        <= '0;
      bus.branch_transmit  <= 1'b0;
      bus.new_pc           <= '0;
      bus.branch_not_taken <= 1'b0;
      bus.retire_transmit  <= 1'b0;
      bus.retire_id        <= '0;
    end else begin
      // wr_ok needs !done and commit needs done, so they never hit the
      // same index and the two updates below cannot conflict.
      if (commit) begin
        done[head] <= 1'b0;
        head       <= head + IDW'(1);
      end
      if (wr_ok) begin
        done[bus.robid] <= 1'b1;
      end
      if (dup) begin
        bus.dup_err <= 1'b1;
      end

      bus.prf_transmit     <= do_prf;
      bus.prf_id           <= do_prf ? h_wbs[3:0] : '0;
      bus.prf_value        <= do_prf ? h_value    : '0;
      bus.retire_transmit  <= do_prf;
      bus.retire_id        <= do_prf ? h_wbs[7:4] : '0;
      bus.branch_transmit  <= do_br;
      bus.new_pc           <= do_br ? h_value     : '0;
      bus.branch_not_taken <= do_br && !h_flags[2];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed bench for reorder_buffer: reset, in-order and out-of-order
//   commit, branch/no-op commits, async reset mid-stream, duplicate writes,
//   simultaneous write/commit of one entry, and head wrap-around.
module tb_reorder_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reorder_buffer_if rob ();

  reorder_buffer #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic pt, input logic [3:0] pid, input logic [7:0] pv,
                         input logic bt, input logic [7:0] pc, input logic bnt,
                         input logic rt, input logic [3:0] rid);
    chk({tag, ".prf_transmit"},     32'(rob.prf_transmit),     32'(pt));
    chk({tag, ".prf_id"},           32'(rob.prf_id),           32'(pid));
    chk({tag, ".prf_value"},        32'(rob.prf_value),        32'(pv));
    chk({tag, ".branch_transmit"},  32'(rob.branch_transmit),  32'(bt));
    chk({tag, ".new_pc"},           32'(rob.new_pc),           32'(pc));
    chk({tag, ".branch_not_taken"}, 32'(rob.branch_not_taken), 32'(bnt));
    chk({tag, ".retire_transmit"},  32'(rob.retire_transmit),  32'(rt));
    chk({tag, ".retire_id"},        32'(rob.retire_id),        32'(rid));
  endtask

  task automatic chk_zero(input string tag);
    chk_out(tag, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic drive(input logic t, input logic [3:0] id, input logic [7:0] fl,
                       input logic [7:0] w, input logic [7:0] v);
    rob.rob_transmit = t;
    rob.robid        = id;
    rob.flags        = fl;
    rob.wbs          = w;
    rob.value        = v;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 8'h00);
  endtask

  // Advance one active edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    #1 rst = 1'b0;
    #2;
    // ---- reset state
    chk_zero("reset");
    chk("reset.dup_err", 32'(rob.dup_err), 32'h0);
    tick();
    tick();
    chk_zero("reset.held");

    // ---- in-order commit; first edge after release accepts the write
    rst = 1'b1;
    drive(1'b1, 4'd0, 8'h02, 8'h53, 8'h2A);
    tick();
    idle();
    chk_zero("b.nobypass");
    tick();
    chk_out("b.commit", 1'b1, 4'h3, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 4'h5);
    tick();
    chk_zero("b.single");

    // ---- out-of-order: robid 2 waits for robid 1 (head=1)
    drive(1'b1, 4'd2, 8'h02, 8'h76, 8'h11);
    tick();
    idle();
    tick();
    chk_zero("c.wait1");
    tick();
    chk_zero("c.wait2");
    drive(1'b1, 4'd1, 8'h02, 8'h98, 8'h22);
    tick();
    idle();
    chk_zero("c.wait3");
    tick();
    chk_out("c.first", 1'b1, 4'h8, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 4'h9);
    tick();
    chk_out("c.second", 1'b1, 4'h6, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 4'h7);
    tick();
    chk_zero("c.idle");

    // ---- branches and a flags=000 commit (upper flag bits ignored), head=3
    drive(1'b1, 4'd3, 8'h01, 8'hAB, 8'h10);
    tick();
    drive(1'b1, 4'd4, 8'h05, 8'hCD, 8'h40);
    tick();
    chk_out("d.not_taken", 1'b0, 4'h0, 8'h00, 1'b1, 8'h10, 1'b1, 1'b0, 4'h0);
    drive(1'b1, 4'd5, 8'hF8, 8'hEF, 8'h99);
    tick();
    chk_out("d.taken", 1'b0, 4'h0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0, 4'h0);
    drive(1'b1, 4'd6, 8'h02, 8'h21, 8'h66);
    tick();
    idle();
    chk_zero("d.noop");
    tick();
    chk_out("d.after_noop", 1'b1, 4'h1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1, 4'h2);

    // ---- async reset mid-stream, head=7, entry 8 pending
    drive(1'b1, 4'd8, 8'h02, 8'h43, 8'h88);
    tick();
    drive(1'b1, 4'd7, 8'h02, 8'h65, 8'h77);
    tick();
    idle();
    tick();
    chk_out("e.pre", 1'b1, 4'h5, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 4'h6);
    #2 rst = 1'b0;
    #1;
    chk_zero("e.async");
    tick();
    chk_zero("e.in_reset");
    rst = 1'b1;
    tick();
    chk_zero("e.stale1");
    tick();
    chk_zero("e.stale2");

    // ---- duplicate write to robid 3 while head=0
    drive(1'b1, 4'd3, 8'h02, 8'h21, 8'h33);
    tick();
    drive(1'b1, 4'd3, 8'h02, 8'hBA, 8'h44);
    tick();
    chk("f.dup_set", 32'(rob.dup_err), 32'h1);
    drive(1'b1, 4'd0, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 4'd1, 8'h00, 8'h00, 8'h00);
    tick();
    drive(1'b1, 4'd2, 8'h00, 8'h00, 8'h00);
    tick();
    idle();
    tick();
    chk_zero("f.noop2");
    tick();
    chk_out("f.kept_first", 1'b1, 4'h1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 4'h2);
    chk("f.dup_sticky", 32'(rob.dup_err), 32'h1);

    // ---- write to the entry committing this cycle (head=4)
    drive(1'b1, 4'd4, 8'h02, 8'h54, 8'h55);
    tick();
    drive(1'b1, 4'd4, 8'h02, 8'h76, 8'h66);
    tick();
    idle();
    chk_out("g.old", 1'b1, 4'h4, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 4'h5);
    tick();
    chk_zero("g.not_done");
    chk("g.dup_sticky", 32'(rob.dup_err), 32'h1);

    // ---- reset clears dup_err asynchronously
    #2 rst = 1'b0;
    #1;
    chk("h.dup_clear", 32'(rob.dup_err), 32'h0);
    tick();
    rst = 1'b1;

    // ---- wrap: robids 0..15 then 0, one per cycle
    for (int i = 0; i <= 17; i++) begin
      if (i < 17)
        drive(1'b1, 4'(i % 16), 8'h02, {4'(15 - (i % 16)), 4'(i % 16)}, 8'(8'hA0 + i));
      else
        idle();
      tick();
      if (i > 0)
        chk_out($sformatf("w.%0d", i - 1), 1'b1, 4'((i - 1) % 16), 8'(8'hA0 + i - 1),
                1'b0, 8'h00, 1'b0, 1'b1, 4'(15 - ((i - 1) % 16)));
    end
    tick();
    chk_zero("w.end");
    drive(1'b1, 4'd1, 8'h02, 8'h10, 8'h5A);
    tick();
    idle();
    tick();
    chk_out("w.head1", 1'b1, 4'h0, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
